// File: rtl/heartbeat_requester_multi_if.sv
// heartbeat_requester_multi_if: request (valid/ready) and ack port bundle of the multi-channel heartbeat requester
interface heartbeat_requester_multi_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int NODE_ID_WIDTH = 8
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  logic                     req_valid;
  logic                     req_ready;
  logic [CW-1:0]            req_channel;
  logic [NODE_ID_WIDTH-1:0] req_dst_id;
  logic [NODE_ID_WIDTH-1:0] req_src_id;
  logic                     ack_valid;
  logic [CW-1:0]            ack_channel;
  modport master (
    output req_valid, req_channel, req_dst_id, req_src_id,
    input  req_ready, ack_valid, ack_channel
  );
  modport slave (
    input  req_valid, req_channel, req_dst_id, req_src_id,
    output req_ready, ack_valid, ack_channel
  );
endinterface

// File: rtl/heartbeat_requester_multi.sv
// heartbeat_requester_multi: periodic heartbeat requests to several neighbours with per-channel ack timeout, alive flag and miss counter
module heartbeat_requester_multi #(
  parameter int NUM_CHANNELS   = 4,
  parameter int NODE_ID_WIDTH  = 8,
  parameter int PERIOD_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_MISSES     = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            enable,
  input  logic [NODE_ID_WIDTH-1:0]                        self_node_id,
  input  logic [NUM_CHANNELS*NODE_ID_WIDTH-1:0]           neighbor_id,
  input  logic [NUM_CHANNELS-1:0]                         channel_en,
  heartbeat_requester_multi_if.master                     bus,
  output logic [NUM_CHANNELS-1:0]                         alive,
  output logic [NUM_CHANNELS*$clog2(MAX_MISSES+1)-1:0]    miss_count,
  output logic [NUM_CHANNELS-1:0]                         overrun
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int MW = $clog2(MAX_MISSES+1);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT} st_t;

  st_t                            st_q [NUM_CHANNELS];
  st_t                            st_d [NUM_CHANNELS];
  logic [TW-1:0]                  tc_q [NUM_CHANNELS];
  logic [TW-1:0]                  tc_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][MW-1:0] miss_q, miss_d;
  logic [NUM_CHANNELS-1:0]        alive_q, alive_d, ovr_q, ovr_d;
  logic [NUM_CHANNELS-1:0]        pres, ackh, cand;
  logic [PW-1:0]                  cnt_q, cnt_d;
  logic                           vld_q, vld_d;
  logic [CW-1:0]                  ch_q, ch_d, ptr_q, ptr_d, gnt;
  logic [NODE_ID_WIDTH-1:0]       dst_q, dst_d, src_q, src_d;
  logic                           tick, hs, found;

  assign tick  = enable && cnt_q == PW'(PERIOD_CYCLES-1);
  assign hs    = vld_q && bus.req_ready;
  assign cnt_d = tick ? '0 : enable ? cnt_q + PW'(1) : cnt_q;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign pres[g] = vld_q && ch_q == CW'(g);
    assign ackh[g] = bus.ack_valid && bus.ack_channel == CW'(g);
    assign cand[g] = st_q[g] == S_PEND && channel_en[g] && !pres[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      st_d[i]    = st_q[i];
      tc_d[i]    = tc_q[i];
      miss_d[i]  = miss_q[i];
      alive_d[i] = alive_q[i];
      ovr_d[i]   = ovr_q[i];
      if (!channel_en[i]) begin
        // a presented request stays on the bus until taken, then the channel parks
        st_d[i]    = pres[i] && !hs ? S_PEND : S_IDLE;
        miss_d[i]  = '0;
        alive_d[i] = 1'b0;
        ovr_d[i]   = 1'b0;
      end else begin
        ovr_d[i] = ovr_q[i] || (tick && st_q[i] != S_IDLE);
        if (st_q[i] == S_IDLE && tick)
          st_d[i] = S_PEND;
        else if (st_q[i] == S_PEND && pres[i] && hs) begin
          st_d[i] = S_WAIT;
          tc_d[i] = '0;
        end else if (st_q[i] == S_WAIT && ackh[i]) begin
          st_d[i]    = S_IDLE;
          miss_d[i]  = '0;
          alive_d[i] = 1'b1;
        end else if (st_q[i] == S_WAIT && tc_q[i] == TW'(TIMEOUT_CYCLES-1)) begin
          st_d[i]    = S_IDLE;
          miss_d[i]  = miss_q[i] + MW'(miss_q[i] != MW'(MAX_MISSES));
          alive_d[i] = alive_q[i] && miss_d[i] != MW'(MAX_MISSES);
        end else if (st_q[i] == S_WAIT)
          tc_d[i] = tc_q[i] + TW'(1);
      end
    end
  end

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!found && cand[(int'(ptr_q) + k) % NUM_CHANNELS]) begin
        found = 1'b1;
        gnt   = CW'((int'(ptr_q) + k) % NUM_CHANNELS);
      end
    end
    vld_d = vld_q;
    ch_d  = ch_q;
    dst_d = dst_q;
    src_d = src_q;
    ptr_d = ptr_q;
    if (!vld_q || hs) begin
      vld_d = found;
      ch_d  = found ? gnt : ch_q;
      dst_d = found ? neighbor_id[int'(gnt)*NODE_ID_WIDTH +: NODE_ID_WIDTH] : dst_q;
      src_d = found ? self_node_id : src_q;
      ptr_d = found ? CW'((int'(gnt) + 1) % NUM_CHANNELS) : ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        st_q[i] <= S_IDLE;
        tc_q[i] <= '0;
      end
      miss_q  <= '0;
      alive_q <= '0;
      ovr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        st_q[i] <= st_d[i];
        tc_q[i] <= tc_d[i];
      end
      miss_q  <= miss_d;
      alive_q <= alive_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.req_valid   = vld_q;
  assign bus.req_channel = ch_q;
  assign bus.req_dst_id  = dst_q;
  assign bus.req_src_id  = src_q;
  assign alive           = alive_q;
  assign miss_count      = miss_q;
  assign overrun         = ovr_q;
endmodule

// File: tb/tb_heartbeat_requester_multi.sv
// tb_heartbeat_requester_multi: directed stimulus with a request scoreboard and an ack-responding monitor
module tb_heartbeat_requester_multi;
  typedef struct packed {int ch; int due;} ack_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        enable = 1;
  logic [7:0]  self_node_id = 8'h10;
  logic [31:0] neighbor_id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  channel_en = 4'b0000;
  logic [3:0]  alive;
  logic [7:0]  miss_count;
  logic [3:0]  overrun;
  int          checks = 0;
  int          errors = 0;
  int          ack_dly = 0;
  int          ecnt = 0;
  int          bcnt = 0;
  logic        tk = 0;
  logic [17:0] exp_q [$];
  ack_t        ack_q [$];
  logic [17:0] exp_e, got_e;

  heartbeat_requester_multi_if #(.NUM_CHANNELS(4), .NODE_ID_WIDTH(8)) bus ();

  heartbeat_requester_multi #(
    .NUM_CHANNELS(4), .NODE_ID_WIDTH(8), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(5), .MAX_MISSES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .self_node_id(self_node_id),
    .neighbor_id(neighbor_id), .channel_en(channel_en), .bus(bus),
    .alive(alive), .miss_count(miss_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // independent period counter: tk marks the edge on which the period wraps
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= 0;
      tk   <= 1'b0;
    end else begin
      tk   <= enable && bcnt == 19;
      bcnt <= enable ? (bcnt == 19 ? 0 : bcnt + 1) : bcnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic after_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tk && n < 40);
    if (!tk) begin
      checks++;
      errors++;
      $display("FAIL tick_wait got=timeout exp=tick");
    end
  endtask

  task automatic push_req(input int ch);
    exp_q.push_back({2'(ch), 8'hA0 + 8'(ch), 8'h10});
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_valid", {31'd0, bus.req_valid}, 0);
    chk("rst_channel", {30'd0, bus.req_channel}, 0);
    chk("rst_dst", {24'd0, bus.req_dst_id}, 0);
    chk("rst_src", {24'd0, bus.req_src_id}, 0);
    chk("rst_alive", {28'd0, alive}, 0);
    chk("rst_miss", {24'd0, miss_count}, 0);
    chk("rst_overrun", {28'd0, overrun}, 0);
    exp_q.delete();
    ack_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // monitor: scores every handshake and returns acks ack_dly edges after it
  initial begin
    bus.ack_valid   = 0;
    bus.ack_channel = 0;
    forever begin
      @(negedge clk);
      bus.ack_valid = 0;
      if (rst) continue;
      for (int k = 0; k < ack_q.size(); k++) begin
        if (ack_q[k].due == ecnt + 1) begin
          bus.ack_valid   = 1;
          bus.ack_channel = 2'(ack_q[k].ch);
          ack_q.delete(k);
          break;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        checks++;
        got_e = {bus.req_channel, bus.req_dst_id, bus.req_src_id};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req got=%h exp=none", got_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            errors++;
            $display("FAIL req got=%h exp=%h", got_e, exp_e);
          end
        end
        if (ack_dly > 0) ack_q.push_back('{ch: int'(bus.req_channel), due: ecnt + 1 + ack_dly});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_miss [6] = '{1, 2, 0, 1, 2, 2};
    int exp_alv  [6] = '{0, 0, 1, 1, 0, 0};
    bus.req_ready = 0;
    @(posedge clk);
    #1;
    do_reset();

    // all four channels, back-to-back, acked two edges after acceptance
    channel_en = 4'b1111;
    bus.req_ready = 1;
    ack_dly = 2;
    after_tick();
    for (int c = 0; c < 4; c++) push_req(c);
    chk("t1_valid_tick", {31'd0, bus.req_valid}, 0);
    step(1);
    chk("t1_valid_rise", {31'd0, bus.req_valid}, 1);
    step(12);
    chk("t1_alive", {28'd0, alive}, 4'b1111);
    chk("t1_miss", {24'd0, miss_count}, 0);
    chk("t1_queue", exp_q.size(), 0);

    // miss counting and saturation on ch0
    do_reset();
    channel_en = 4'b0001;
    for (int p = 0; p < 6; p++) begin
      ack_dly = (p == 2) ? 2 : 0;
      after_tick();
      push_req(0);
      step(12);
      chk($sformatf("t2_miss_p%0d", p + 1), {24'd0, miss_count}, exp_miss[p]);
      chk($sformatf("t2_alive_p%0d", p + 1), {28'd0, alive}, exp_alv[p]);
    end

    // backpressure with two pending, then round-robin order
    do_reset();
    channel_en = 4'b0011;
    bus.req_ready = 0;
    ack_dly = 2;
    after_tick();
    push_req(0);
    push_req(1);
    chk("t3_valid_tick", {31'd0, bus.req_valid}, 0);
    for (int c = 0; c < 11; c++) begin
      step(1);
      chk("t3_hold_valid", {31'd0, bus.req_valid}, 1);
      chk("t3_hold_ch", {30'd0, bus.req_channel}, 0);
      chk("t3_hold_dst", {24'd0, bus.req_dst_id}, 32'hA0);
    end
    bus.req_ready = 1;
    step(5);
    chk("t3_queue1", exp_q.size(), 0);
    after_tick();
    push_req(0);
    push_req(1);
    step(15);
    chk("t3_queue2", exp_q.size(), 0);

    // stall across a whole period raises overrun, one request only
    channel_en = 4'b0001;
    bus.req_ready = 0;
    after_tick();
    push_req(0);
    step(10);
    chk("t4_ovr_before", {28'd0, overrun}, 0);
    after_tick();
    chk("t4_ovr_after", {28'd0, overrun}, 4'b0001);
    bus.req_ready = 1;
    step(15);
    chk("t4_ovr_sticky", {28'd0, overrun}, 4'b0001);
    chk("t4_queue", exp_q.size(), 0);

    // ack on the timeout edge wins; stray ack on an idle channel is ignored
    channel_en = 4'b1100;
    ack_dly = 0;
    after_tick();
    push_req(2);
    push_req(3);
    step(12);
    chk("t5_miss_a", {24'd0, miss_count}, 8'h50);
    chk("t5_alive_a", {28'd0, alive}, 0);
    chk("t5_ovr_cleared", {28'd0, overrun}, 0);
    ack_q.push_back('{ch: 3, due: ecnt + 1});
    step(3);
    chk("t5_stray_miss", {24'd0, miss_count}, 8'h50);
    chk("t5_stray_alive", {28'd0, alive}, 0);
    ack_dly = 5;
    after_tick();
    push_req(2);
    push_req(3);
    step(12);
    chk("t5_miss_b", {24'd0, miss_count}, 0);
    chk("t5_alive_b", {28'd0, alive}, 4'b1100);
    chk("t5_queue", exp_q.size(), 0);

    // reset while ch1 waits for its ack and ch2 is on the bus
    channel_en = 4'b0110;
    bus.req_ready = 0;
    ack_dly = 0;
    after_tick();
    push_req(1);
    push_req(2);
    bus.req_ready = 1;
    step(2);
    bus.req_ready = 0;
    step(1);
    chk("t6_pre_valid", {31'd0, bus.req_valid}, 1);
    chk("t6_pre_ch", {30'd0, bus.req_channel}, 2);
    chk("t6_pre_alive", {28'd0, alive}, 4'b0100);
    do_reset();
    chk("t6_post_valid", {31'd0, bus.req_valid}, 0);
    chk("t6_post_alive", {28'd0, alive}, 0);
    bus.req_ready = 1;
    ack_dly = 2;
    step(5);
    chk("t6_idle_valid", {31'd0, bus.req_valid}, 0);
    after_tick();
    push_req(1);
    push_req(2);
    chk("t6_valid_tick", {31'd0, bus.req_valid}, 0);
    step(1);
    chk("t6_valid_rise", {31'd0, bus.req_valid}, 1);
    chk("t6_first_ch", {30'd0, bus.req_channel}, 1);
    step(15);
    chk("t6_queue", exp_q.size(), 0);
    chk("t6_alive", {28'd0, alive}, 4'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
